// File: rtl/gshare_sa_pkg.sv
// bpu_pkg: default predictor parameters and the width-generic saturating-counter step
package bpu_pkg;
    localparam int PC_WIDTH_DEF = 32;
    localparam int INST_WIDTH_DEF = 32;
    localparam int BTB_SET_W_DEF = 7;
    localparam int BTB_WAYS_DEF = 4;
    localparam int GHR_W_DEF = 8;
    localparam int N_BIT_SCHEME_DEF = 2;
    function automatic int unsigned sat_cnt_next(input int unsigned cnt, input logic taken, input int unsigned limit);
        return taken ? ((cnt >= limit) ? limit : cnt + 32'd1) : ((cnt == 32'd0) ? 32'd0 : cnt - 32'd1);
    endfunction
endpackage

// File: rtl/gshare_sa_if.sv
// gshare_sa_if: fetch lookup (pc, pred_en -> hit, taken, next_pc, pred_ghr) and execute resolution (upd_*) bundle
interface gshare_sa_if import bpu_pkg::*; #(
    parameter int PC_WIDTH = PC_WIDTH_DEF,
    parameter int GHR_W = GHR_W_DEF
);
    logic [PC_WIDTH-1:0] pc;
    logic pred_en;
    logic hit;
    logic taken;
    logic [PC_WIDTH-1:0] next_pc;
    logic [GHR_W-1:0] pred_ghr;
    logic upd_vld;
    logic [PC_WIDTH-1:0] upd_pc;
    logic [PC_WIDTH-1:0] upd_br_addr;
    logic upd_taken;
    logic [GHR_W-1:0] upd_ghr;
    logic upd_mispred;
    modport master (
        output pc, pred_en, upd_vld, upd_pc, upd_br_addr, upd_taken, upd_ghr, upd_mispred,
        input hit, taken, next_pc, pred_ghr
    );
    modport slave (
        input pc, pred_en, upd_vld, upd_pc, upd_br_addr, upd_taken, upd_ghr, upd_mispred,
        output hit, taken, next_pc, pred_ghr
    );
endinterface

// File: rtl/gshare_sa_btb.sv
// bpu_btb_sa: set-associative BTB; rd_pc -> rd_hit/rd_target lookup, wr_en/wr_pc/wr_target refresh-or-allocate with per-set round-robin victim
module bpu_btb_sa import bpu_pkg::*; #(
    parameter int PC_WIDTH = PC_WIDTH_DEF,
    parameter int INST_WIDTH = INST_WIDTH_DEF,
    parameter int BTB_SET_W = BTB_SET_W_DEF,
    parameter int BTB_WAYS = BTB_WAYS_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic [PC_WIDTH-1:0] rd_pc,
    output logic rd_hit,
    output logic [PC_WIDTH-1:0] rd_target,
    input  logic wr_en,
    input  logic [PC_WIDTH-1:0] wr_pc,
    input  logic [PC_WIDTH-1:0] wr_target
);
    localparam int LOW = $clog2(INST_WIDTH / 8);
    localparam int TAG_W = PC_WIDTH - BTB_SET_W - LOW;
    localparam int WAY_W = $clog2(BTB_WAYS);
    localparam int SETS = 2 ** BTB_SET_W;
    typedef struct packed {
        logic vld;
        logic [TAG_W-1:0] tag;
        logic [PC_WIDTH-1:0] target;
    } BtbEntry_s;
    BtbEntry_s btb [SETS][BTB_WAYS];
    logic [WAY_W-1:0] rr [SETS];
    logic [BTB_SET_W-1:0] rd_set, wr_set;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic [WAY_W-1:0] rd_way, wr_way, victim;
    logic wr_hit;
    logic unused_low;
    assign rd_set = rd_pc[LOW +: BTB_SET_W];
    assign wr_set = wr_pc[LOW +: BTB_SET_W];
    assign rd_tag = rd_pc[PC_WIDTH-1 -: TAG_W];
    assign wr_tag = wr_pc[PC_WIDTH-1 -: TAG_W];
    assign unused_low = ^{rd_pc[LOW-1:0], wr_pc[LOW-1:0]};
    always_comb begin
        rd_hit = 1'b0;
        rd_way = '0;
        wr_hit = 1'b0;
        wr_way = '0;
        victim = rr[wr_set];
        for (int w = BTB_WAYS - 1; w >= 0; w--) begin
            if (btb[rd_set][w].vld && btb[rd_set][w].tag == rd_tag) begin
                rd_hit = 1'b1;
                rd_way = WAY_W'(w);
            end
            if (btb[wr_set][w].vld && btb[wr_set][w].tag == wr_tag) begin
                wr_hit = 1'b1;
                wr_way = WAY_W'(w);
            end
            victim = btb[wr_set][w].vld ? victim : WAY_W'(w);
        end
    end
    assign rd_target = btb[rd_set][rd_way].target;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < SETS; s++) begin
                rr[s] <= '0;
                for (int w = 0; w < BTB_WAYS; w++) btb[s][w].vld <= 1'b0;
            end
        end else if (wr_en && wr_hit) begin
            btb[wr_set][wr_way].target <= wr_target;
        end else if (wr_en) begin
            btb[wr_set][victim] <= '{vld: 1'b1, tag: wr_tag, target: wr_target};
            rr[wr_set] <= rr[wr_set] + 1'b1;
        end
    end
endmodule

// File: rtl/gshare_sa.sv
// gshare_sa: gshare PHT + set-associative BTB predictor with speculative GHR; i_clk, i_rst, bpu (gshare_sa_if.slave)
module gshare_sa import bpu_pkg::*; #(
    parameter int PC_WIDTH = PC_WIDTH_DEF,
    parameter int INST_WIDTH = INST_WIDTH_DEF,
    parameter int BTB_SET_W = BTB_SET_W_DEF,
    parameter int BTB_WAYS = BTB_WAYS_DEF,
    parameter int GHR_W = GHR_W_DEF,
    parameter int N_BIT_SCHEME = N_BIT_SCHEME_DEF
) (
    input logic i_clk,
    input logic i_rst,
    gshare_sa_if.slave bpu
);
    localparam int LOW = $clog2(INST_WIDTH / 8);
    localparam int PHT_D = 2 ** GHR_W;
    localparam int CNT_MAX = 2 ** N_BIT_SCHEME - 1;
    localparam logic [N_BIT_SCHEME-1:0] WEAK_T = N_BIT_SCHEME'(2 ** (N_BIT_SCHEME - 1));
    logic [N_BIT_SCHEME-1:0] pht [PHT_D];
    logic [GHR_W-1:0] spec_ghr, rd_idx, wr_idx;
    logic btb_hit, taken;
    logic [PC_WIDTH-1:0] btb_target;
    bpu_btb_sa #(
        .PC_WIDTH(PC_WIDTH),
        .INST_WIDTH(INST_WIDTH),
        .BTB_SET_W(BTB_SET_W),
        .BTB_WAYS(BTB_WAYS)
    ) u_btb (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .rd_pc(bpu.pc),
        .rd_hit(btb_hit),
        .rd_target(btb_target),
        .wr_en(bpu.upd_vld && bpu.upd_taken),
        .wr_pc(bpu.upd_pc),
        .wr_target(bpu.upd_br_addr)
    );
    assign rd_idx = spec_ghr ^ bpu.pc[LOW +: GHR_W];
    assign wr_idx = bpu.upd_ghr ^ bpu.upd_pc[LOW +: GHR_W];
    assign taken = btb_hit && pht[rd_idx][N_BIT_SCHEME-1];
    assign bpu.hit = btb_hit;
    assign bpu.taken = taken;
    assign bpu.next_pc = taken ? btb_target : bpu.pc + PC_WIDTH'(4);
    assign bpu.pred_ghr = spec_ghr;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < PHT_D; i++) pht[i] <= WEAK_T;
            spec_ghr <= '0;
        end else begin
            if (bpu.upd_vld) pht[wr_idx] <= N_BIT_SCHEME'(sat_cnt_next(32'(pht[wr_idx]), bpu.upd_taken, CNT_MAX));
            spec_ghr <= (bpu.upd_vld && bpu.upd_mispred) ? {bpu.upd_ghr[GHR_W-2:0], bpu.upd_taken}
                      : (bpu.pred_en && btb_hit) ? {spec_ghr[GHR_W-2:0], taken} : spec_ghr;
        end
    end
endmodule

// File: tb/tb_gshare_sa.sv
// tb_gshare_sa: directed and randomized checks of gshare_sa against a behavioural predictor model
module tb_gshare_sa;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    gshare_sa_if #(.PC_WIDTH(32), .GHR_W(8)) bus ();
    gshare_sa dut (.i_clk(clk), .i_rst(rst), .bpu(bus));
    logic m_vld [128][4];
    logic [31:0] m_pc [128][4];
    logic [31:0] m_tgt [128][4];
    int m_rr [128];
    int m_pht [256];
    logic [7:0] m_ghr;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic int set_of(input logic [31:0] pc);
        return int'(pc[8:2]);
    endfunction
    function automatic logic same_tag(input logic [31:0] a, input logic [31:0] b);
        return a[31:9] == b[31:9];
    endfunction
    task automatic m_reset();
        for (int s = 0; s < 128; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < 4; w++) m_vld[s][w] = 1'b0;
        end
        for (int i = 0; i < 256; i++) m_pht[i] = 2;
        m_ghr = 8'h00;
    endtask
    task automatic m_predict(input logic [31:0] pc, output logic h, output logic t, output logic [31:0] n);
        int s;
        logic [31:0] tgt;
        s = set_of(pc);
        tgt = 32'h0;
        h = 1'b0;
        for (int w = 0; w < 4; w++)
            if (!h && m_vld[s][w] && same_tag(m_pc[s][w], pc)) begin
                h = 1'b1;
                tgt = m_tgt[s][w];
            end
        t = h && (m_pht[int'(m_ghr ^ pc[9:2])] >= 2);
        n = t ? tgt : pc + 32'd4;
    endtask
    task automatic m_update(input logic en, input logic h, input logic t, input logic uv, input logic [31:0] upc,
                            input logic [31:0] utgt, input logic ut, input logic [7:0] ug, input logic um);
        int s;
        int idx;
        int v;
        s = set_of(upc);
        idx = int'(ug ^ upc[9:2]);
        v = -1;
        if (uv && um) m_ghr = {ug[6:0], ut};
        else if (en && h) m_ghr = {m_ghr[6:0], t};
        if (uv) m_pht[idx] = ut ? ((m_pht[idx] + 1 > 3) ? 3 : m_pht[idx] + 1) : ((m_pht[idx] - 1 < 0) ? 0 : m_pht[idx] - 1);
        if (uv && ut) begin
            for (int w = 0; w < 4; w++) if (v < 0 && m_vld[s][w] && same_tag(m_pc[s][w], upc)) v = w;
            if (v >= 0) m_tgt[s][v] = utgt;
            else begin
                for (int w = 3; w >= 0; w--) if (!m_vld[s][w]) v = w;
                if (v < 0) v = m_rr[s];
                m_vld[s][v] = 1'b1;
                m_pc[s][v] = upc;
                m_tgt[s][v] = utgt;
                m_rr[s] = (m_rr[s] + 1) % 4;
            end
        end
    endtask
    task automatic step(input logic [31:0] pc, input logic en, input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                        input logic ut, input logic [7:0] ug, input logic um, input logic r);
        logic h, t;
        logic [31:0] n;
        bus.pc = pc;
        bus.pred_en = en;
        bus.upd_vld = uv;
        bus.upd_pc = upc;
        bus.upd_br_addr = utgt;
        bus.upd_taken = ut;
        bus.upd_ghr = ug;
        bus.upd_mispred = um;
        rst = r;
        #2;
        m_predict(pc, h, t, n);
        chk("model_hit", 32'(bus.hit), 32'(h));
        chk("model_taken", 32'(bus.taken), 32'(t));
        chk("model_next_pc", bus.next_pc, n);
        chk("model_pred_ghr", 32'(bus.pred_ghr), 32'(m_ghr));
        @(posedge clk);
        #1;
        if (r) m_reset();
        else m_update(en, h, t, uv, upc, utgt, ut, ug, um);
        bus.pred_en = 1'b0;
        bus.upd_vld = 1'b0;
        rst = 1'b0;
    endtask
    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic t, input logic [7:0] g, input logic m);
        step(pc, 1'b0, 1'b1, pc, tgt, t, g, m, 1'b0);
    endtask
    task automatic probe(input string tag, input logic [31:0] pc, input logic h, input logic t, input logic [31:0] n, input logic [7:0] g);
        bus.pc = pc;
        #2;
        chk({tag, "_hit"}, 32'(bus.hit), 32'(h));
        chk({tag, "_taken"}, 32'(bus.taken), 32'(t));
        chk({tag, "_next_pc"}, bus.next_pc, n);
        chk({tag, "_pred_ghr"}, 32'(bus.pred_ghr), 32'(g));
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus.pc = 32'h0;
        bus.pred_en = 1'b0;
        bus.upd_vld = 1'b0;
        bus.upd_pc = 32'h0;
        bus.upd_br_addr = 32'h0;
        bus.upd_taken = 1'b0;
        bus.upd_ghr = 8'h00;
        bus.upd_mispred = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        probe("reset", 32'h100, 1'b0, 1'b0, 32'h104, 8'h00);
        upd(32'h100, 32'h400, 1'b1, 8'h00, 1'b0);
        probe("alloc", 32'h100, 1'b1, 1'b1, 32'h400, 8'h00);
        for (int i = 0; i < 5; i++) upd(32'(i * 32'h200), 32'(i * 32'h200 + 32'h1000), 1'b1, 8'h00, 1'b0);
        probe("evict_000", 32'h000, 1'b0, 1'b0, 32'h004, 8'h00);
        probe("keep_200", 32'h200, 1'b1, 1'b1, 32'h1200, 8'h00);
        probe("keep_800", 32'h800, 1'b1, 1'b1, 32'h1800, 8'h00);
        upd(32'ha00, 32'h1a00, 1'b1, 8'h00, 1'b0);
        probe("evict_200", 32'h200, 1'b0, 1'b0, 32'h204, 8'h00);
        probe("alloc_a00", 32'ha00, 1'b1, 1'b1, 32'h1a00, 8'h00);
        probe("keep_400", 32'h400, 1'b1, 1'b1, 32'h1400, 8'h00);
        for (int i = 0; i < 3; i++) step(32'h100, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0);
        probe("ghr_shift", 32'h100, 1'b1, 1'b1, 32'h400, 8'h07);
        step(32'h100, 1'b1, 1'b1, 32'h100, 32'h400, 1'b0, 8'h01, 1'b1, 1'b0);
        probe("ghr_recover", 32'h100, 1'b1, 1'b1, 32'h400, 8'h02);
        for (int i = 0; i < 4; i++) upd(32'h100, 32'h400, 1'b0, 8'h00, 1'b1);
        probe("pht_floor", 32'h100, 1'b1, 1'b0, 32'h104, 8'h00);
        step(32'h100, 1'b1, 1'b1, 32'h200, 32'h999, 1'b1, 8'h00, 1'b0, 1'b1);
        probe("rst_miss_100", 32'h100, 1'b0, 1'b0, 32'h104, 8'h00);
        probe("rst_miss_a00", 32'ha00, 1'b0, 1'b0, 32'ha04, 8'h00);
        probe("rst_miss_200", 32'h200, 1'b0, 1'b0, 32'h204, 8'h00);
        probe("pc_wrap", 32'hffff_ffff, 1'b0, 1'b0, 32'h0000_0003, 8'h00);
        upd(32'h100, 32'h800, 1'b1, 8'h00, 1'b0);
        probe("post_rst_alloc", 32'h100, 1'b1, 1'b1, 32'h800, 8'h00);
        upd(32'h100, 32'h800, 1'b1, 8'h00, 1'b0);
        upd(32'h100, 32'h800, 1'b1, 8'h00, 1'b0);
        upd(32'h100, 32'h800, 1'b0, 8'h00, 1'b0);
        probe("pht_ceiling", 32'h100, 1'b1, 1'b1, 32'h800, 8'h00);
        repeat (400) begin
            logic [31:0] p, q;
            p = (32'($urandom_range(0, 5)) << 9) | (32'($urandom_range(0, 3)) << 2);
            q = (32'($urandom_range(0, 5)) << 9) | (32'($urandom_range(0, 3)) << 2);
            step(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), q, $urandom, 1'($urandom_range(0, 1)),
                 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
